// File: rtl/vga_scan_driver.sv
// vga_scan_driver: free-running raster scan generator.
// Drives the pixel coordinate bus to the renderers, takes their intensity back
// and emits pixel-aligned sync, display-enable and pixel data, plus line/frame
// tick pulses for pacing animation logic.
module vga_scan_driver #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] h_readwire,
  output logic [9:0] v_readwire,
  input  logic [3:0] colorv,
  output logic [3:0] pix_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit compare constants so a sync end equal to 1024 cannot overflow
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_last;
  logic        v_last;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;

  logic [PIX_LATENCY-1:0] de_sr;
  logic [PIX_LATENCY-1:0] hs_sr;
  logic [PIX_LATENCY-1:0] vs_sr;
  logic                   de_d;
  logic                   hs_d;
  logic                   vs_d;

  // Raw timing decode from the current coordinate
  always_comb begin
    h_ext  = {1'b0, h_readwire};
    v_ext  = {1'b0, v_readwire};
    h_last = (h_readwire == H_LAST);
    v_last = (v_readwire == V_LAST);
    de_r   = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hs_r   = !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
    vs_r   = !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
  end

  // Coordinate counters and wrap ticks, advancing only on pixel enables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_readwire <= '0;
      v_readwire <= '0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= pix_ce && h_last;
      frame_tick <= pix_ce && h_last && v_last;
      if (pix_ce) begin
        if (h_last) begin
          h_readwire <= '0;
          v_readwire <= v_last ? '0 : v_readwire + 10'd1;
        end else begin
          h_readwire <= h_readwire + 10'd1;
        end
      end
    end
  end

  // Delay line matching the renderer latency; shifts every clk, not per enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_sr <= '0;
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      de_sr[0] <= de_r;
      hs_sr[0] <= hs_r;
      vs_sr[0] <= vs_r;
      for (int unsigned i = 1; i < PIX_LATENCY; i++) begin
        de_sr[i] <= de_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end

  assign de_d = de_sr[PIX_LATENCY-1];
  assign hs_d = hs_sr[PIX_LATENCY-1];
  assign vs_d = vs_sr[PIX_LATENCY-1];

  // Output registers: pixel data blanked outside the active area
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de      <= 1'b0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      pix_out <= '0;
    end else begin
      de      <= de_d;
      hsync   <= hs_d;
      vsync   <= vs_d;
      pix_out <= de_d ? colorv : '0;
    end
  end

endmodule
